// File: rtl/slc3_alu_pkg.sv
// Shared LC-3 operate-instruction types for the ALU, its sequencer and the control unit.
// Opcodes, ALU control encoding, sequencer states and imm5 sign extension.
package slc3_alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_ERR
  } seq_state_t;

  typedef struct packed {
    alu_ctrl_t   ctrl;
    logic        use_imm;
    logic        legal;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic [4:0]  imm5;
  } dec_t;

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
    return {{(DATA_W-5){v[4]}}, v};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an LC-3 operate instruction into ALU control,
// operand source and register-field selects.
import slc3_alu_pkg::*;

module alu_op_decode (
  input  logic [15:0] instr_i,
  output dec_t        dec_o
);

  logic [3:0] op;

  assign op = instr_i[15:12];

  always_comb begin
    dec_o.ctrl    = ALU_PASS;
    dec_o.use_imm = 1'b0;
    dec_o.legal   = 1'b0;
    dec_o.sr1     = instr_i[8:6];
    dec_o.sr2     = instr_i[2:0];
    dec_o.dr      = instr_i[11:9];
    dec_o.imm5    = instr_i[4:0];
    unique case (1'b1)
      (op == OP_ADD): begin
        dec_o.ctrl    = ALU_ADD;
        dec_o.use_imm = instr_i[5];
        dec_o.legal   = 1'b1;
      end
      (op == OP_AND): begin
        dec_o.ctrl    = ALU_AND;
        dec_o.use_imm = instr_i[5];
        dec_o.legal   = 1'b1;
      end
      // NOT has no second operand, so bit 5 is don't-care
      (op == OP_NOT): begin
        dec_o.ctrl    = ALU_NOT;
        dec_o.legal   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-cycle controller for LC-3 ADD/AND/NOT: read, execute on the
// external ALU, write back to DR and update the condition codes.
import slc3_alu_pkg::*;

module alu_op_sequencer #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [WIDTH-1:0]  instr,
  output logic [REG_AW-1:0] rf_sr1_addr,
  output logic [REG_AW-1:0] rf_sr2_addr,
  input  logic [WIDTH-1:0]  rf_sr1_data,
  input  logic [WIDTH-1:0]  rf_sr2_data,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_dr_addr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic [2:0]        nzp,
  output logic              done,
  output logic              illegal
);

  seq_state_t        state_q, state_d;
  dec_t              dec_in;
  alu_ctrl_t         ctrl_q, ctrl_d;
  logic              use_imm_q, use_imm_d;
  logic [4:0]        imm5_q, imm5_d;
  logic [REG_AW-1:0] dr_q, dr_d;
  logic [REG_AW-1:0] sr1_q, sr1_d;
  logic [REG_AW-1:0] sr2_q, sr2_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [2:0]        nzp_q, nzp_d;
  logic [WIDTH-1:0]  imm_ext;

  alu_op_decode u_dec (
    .instr_i (instr[15:0]),
    .dec_o   (dec_in)
  );

  assign imm_ext     = WIDTH'(signed'(sext5(imm5_q)));
  assign rf_sr1_addr = sr1_q;
  assign rf_sr2_addr = sr2_q;
  assign rf_dr_addr  = dr_q;
  assign rf_wdata    = res_q;
  assign nzp         = nzp_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= ALU_PASS;
      use_imm_q <= 1'b0;
      imm5_q    <= '0;
      dr_q      <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      nzp_q     <= 3'b010;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      use_imm_q <= use_imm_d;
      imm5_q    <= imm5_d;
      dr_q      <= dr_d;
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      nzp_q     <= nzp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    use_imm_d   = use_imm_q;
    imm5_d      = imm5_q;
    dr_d        = dr_q;
    sr1_d       = sr1_q;
    sr2_d       = sr2_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    nzp_d       = nzp_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    alu_ctrl    = ALU_PASS;
    alu_a       = '0;
    alu_b       = '0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          // Read addresses only move for legal ops
          if (dec_in.legal) begin
            state_d   = S_READ;
            ctrl_d    = dec_in.ctrl;
            use_imm_d = dec_in.use_imm;
            imm5_d    = dec_in.imm5;
            dr_d      = REG_AW'(dec_in.dr);
            sr1_d     = REG_AW'(dec_in.sr1);
            sr2_d     = REG_AW'(dec_in.sr2);
          end else begin
            state_d   = S_ERR;
          end
        end
      end
      S_READ: begin
        opa_d   = rf_sr1_data;
        opb_d   = use_imm_q ? imm_ext : rf_sr2_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_ctrl = ctrl_q;
        alu_a    = opa_q;
        alu_b    = opb_q;
        res_d    = alu_result;
        state_d  = S_WB;
      end
      S_WB: begin
        rf_we = 1'b1;
        done  = 1'b1;
        if (res_q[WIDTH-1])    nzp_d = 3'b100;
        else if (res_q == '0)  nzp_d = 3'b010;
        else                   nzp_d = 3'b001;
        state_d = S_IDLE;
      end
      S_ERR: begin
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural register file
// and ALU; vector table plus illegal, reset-abort and spacing sequences.
module tb_alu_op_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [2:0]  rf_sr1_addr, rf_sr2_addr;
  logic [15:0] rf_sr1_data, rf_sr2_data;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_ctrl;
  logic [15:0] alu_result;
  logic        rf_we;
  logic [2:0]  rf_dr_addr;
  logic [15:0] rf_wdata;
  logic [2:0]  nzp;
  logic        done;
  logic        illegal;

  logic [15:0] regs [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  int          wcount = 0;
  int          cyc = 0;
  int          hs_cyc [$];
  int          passed = 0;
  int          total = 0;

  alu_op_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_sr1_addr (rf_sr1_addr),
    .rf_sr2_addr (rf_sr2_addr),
    .rf_sr1_data (rf_sr1_data),
    .rf_sr2_data (rf_sr2_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .rf_we       (rf_we),
    .rf_dr_addr  (rf_dr_addr),
    .rf_wdata    (rf_wdata),
    .nzp         (nzp),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 Clk = ~Clk;

  assign rf_sr1_data = regs[rf_sr1_addr];
  assign rf_sr2_data = regs[rf_sr2_addr];

  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a & alu_b;
      2'b10:   alu_result = ~alu_a;
      default: alu_result = alu_a;
    endcase
  end

  always @(posedge Clk) begin
    if (pre_we) regs[pre_addr] <= pre_data;
    if (rf_we)  regs[rf_dr_addr] <= rf_wdata;
    if (rf_we)  wcount <= wcount + 1;
    cyc <= cyc + 1;
    if (instr_valid && instr_ready && !Reset) hs_cyc.push_back(cyc);
  end

  typedef struct {
    logic [2:0]  ra;
    logic [15:0] va;
    logic [2:0]  rb;
    logic [15:0] vb;
    logic [15:0] ins;
    logic [1:0]  ctl;
    logic [2:0]  dr;
    logic [15:0] wd;
    logic [2:0]  nzp;
  } vec_t;

  vec_t v [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge Clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge Clk);
    pre_we   = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t t;
    t = v[i];
    preload(t.ra, t.va);
    preload(t.rb, t.vb);
    @(negedge Clk);
    chk($sformatf("v%0d ready", i), 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = t.ins;
    @(posedge Clk);
    #1;
    instr_valid = 1'b0;
    chk($sformatf("v%0d read we", i), 32'(rf_we), 32'd0);
    chk($sformatf("v%0d sr1", i), 32'(rf_sr1_addr), 32'(t.ins[8:6]));
    @(posedge Clk);
    #1;
    chk($sformatf("v%0d ctrl", i), 32'(alu_ctrl), 32'(t.ctl));
    @(posedge Clk);
    #1;
    chk($sformatf("v%0d we", i), 32'(rf_we), 32'd1);
    chk($sformatf("v%0d done", i), 32'(done), 32'd1);
    chk($sformatf("v%0d dr", i), 32'(rf_dr_addr), 32'(t.dr));
    chk($sformatf("v%0d wdata", i), 32'(rf_wdata), 32'(t.wd));
    @(posedge Clk);
    #1;
    chk($sformatf("v%0d nzp", i), 32'(nzp), 32'(t.nzp));
    chk($sformatf("v%0d ready2", i), 32'(instr_ready), 32'd1);
    chk($sformatf("v%0d we off", i), 32'(rf_we), 32'd0);
    chk($sformatf("v%0d regfile", i), 32'(regs[t.dr]), 32'(t.wd));
  endtask

  initial begin
    v[0] = '{3'd1, 16'h0005, 3'd2, 16'h0003, 16'h1642,
             2'b00, 3'd3, 16'h0008, 3'b001};
    v[1] = '{3'd0, 16'h0000, 3'd0, 16'h0000, 16'h103F,
             2'b00, 3'd0, 16'hFFFF, 3'b100};
    v[2] = '{3'd0, 16'h7FFF, 3'd0, 16'h7FFF, 16'h1021,
             2'b00, 3'd0, 16'h8000, 3'b100};
    v[3] = '{3'd5, 16'h1234, 3'd5, 16'h1234, 16'h5960,
             2'b01, 3'd4, 16'h0000, 3'b010};
    v[4] = '{3'd7, 16'h00FF, 3'd7, 16'h00FF, 16'h9DFF,
             2'b10, 3'd6, 16'hFF00, 3'b100};
    v[5] = '{3'd2, 16'h0F0F, 3'd3, 16'h00FF, 16'h5283,
             2'b01, 3'd1, 16'h000F, 3'b001};

    #1 Reset = 1'b1;
    #2;
    chk("rst ready", 32'(instr_ready), 32'd1);
    chk("rst we", 32'(rf_we), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst nzp", 32'(nzp), 32'b010);
    chk("rst ctrl", 32'(alu_ctrl), 32'b11);
    chk("rst alu_a", 32'(alu_a), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // illegal opcode: one-cycle error pulse, no write, flags kept
    @(negedge Clk);
    instr_valid = 1'b1;
    instr       = 16'h0000;
    @(posedge Clk);
    #1;
    instr_valid = 1'b0;
    chk("ill pulse", 32'(illegal), 32'd1);
    chk("ill we", 32'(rf_we), 32'd0);
    chk("ill done", 32'(done), 32'd0);
    chk("ill busy", 32'(instr_ready), 32'd0);
    @(posedge Clk);
    #1;
    chk("ill clear", 32'(illegal), 32'd0);
    chk("ill ready", 32'(instr_ready), 32'd1);
    chk("ill nzp", 32'(nzp), 32'b001);
    chk("ill writes", 32'(wcount), 32'd6);

    // reset in EXEC with instr_valid held high
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    preload(3'd3, 16'hAAAA);
    @(negedge Clk);
    instr_valid = 1'b1;
    instr       = 16'h1642;
    @(posedge Clk);
    #1;
    chk("abort busy", 32'(instr_ready), 32'd0);
    @(posedge Clk);
    #1;
    chk("abort exec ctrl", 32'(alu_ctrl), 32'b00);
    chk("abort exec a", 32'(alu_a), 32'h0005);
    chk("abort exec b", 32'(alu_b), 32'h0003);
    Reset       = 1'b1;
    instr_valid = 1'b0;
    #1;
    chk("abort ready", 32'(instr_ready), 32'd1);
    chk("abort ctrl", 32'(alu_ctrl), 32'b11);
    chk("abort alu_a", 32'(alu_a), 32'd0);
    chk("abort we", 32'(rf_we), 32'd0);
    chk("abort nzp", 32'(nzp), 32'b010);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort regfile", 32'(regs[3]), 32'hAAAA);
    chk("abort writes", 32'(wcount), 32'd6);

    // valid held high: accepted once every four cycles
    @(negedge Clk);
    hs_cyc.delete();
    instr       = 16'h1642;
    instr_valid = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    instr_valid = 1'b0;
    chk("b2b count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() >= 3) begin
      chk("b2b gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd4);
      chk("b2b gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd4);
    end
    chk("b2b writes", 32'(wcount), 32'd9);
    chk("b2b regfile", 32'(regs[3]), 32'h0008);
    chk("b2b nzp", 32'(nzp), 32'b001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
